// File: rtl/decode_upperimm_stage.sv
// decode_upperimm_stage: LUI/AUIPC/JAL decode with a small output FIFO for downstream backpressure
module decode_upperimm_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_code,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      alu_control,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] target,
    output logic            jump,
    output logic            wb_en,
    output logic            misaligned,
    output logic            illegal,
    output logic [31:0]     decode_count
);
    localparam logic [4:0] ALU_LUI   = 5'd20;
    localparam logic [4:0] ALU_AUIPC = 5'd21;
    localparam logic [4:0] ALU_JAL   = 5'd22;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] target;
        logic            jump;
        logic            wb_en;
        logic            misaligned;
        logic            illegal;
    } entry_t;

    entry_t          dec, head;
    entry_t          mem [DEPTH];
    logic [CW-1:0]   count;
    logic [PW-1:0]   wptr, rptr;
    logic            push, pop, is_lui, is_auipc, is_jal;
    logic [XLEN-1:0] u_imm, j_imm;

    assign in_ready  = count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign is_lui    = instruction_code[6:0] == 7'b0110111;
    assign is_auipc  = instruction_code[6:0] == 7'b0010111;
    assign is_jal    = instruction_code[6:0] == 7'b1101111;
    assign u_imm     = XLEN'($signed({instruction_code[31:12], 12'b0}));
    assign j_imm     = XLEN'($signed({instruction_code[31], instruction_code[19:12],
                                      instruction_code[20], instruction_code[30:21], 1'b0}));

    // decode the offered instruction into a FIFO entry; illegal opcodes carry only the flag
    always_comb begin
        dec            = '0;
        dec.illegal    = !(is_lui || is_auipc || is_jal);
        dec.rd         = dec.illegal ? 5'd0 : instruction_code[11:7];
        dec.imm        = is_jal ? j_imm : dec.illegal ? '0 : u_imm;
        dec.alu        = is_lui ? ALU_LUI : is_auipc ? ALU_AUIPC : is_jal ? ALU_JAL : 5'd0;
        dec.result     = is_lui ? u_imm : is_auipc ? pc + u_imm : is_jal ? pc + XLEN'(4) : '0;
        dec.target     = is_jal ? pc + j_imm : '0;
        dec.jump       = is_jal;
        dec.wb_en      = !dec.illegal && dec.rd != 5'd0;
        dec.misaligned = is_jal && dec.target[1:0] != 2'b00;
    end

    // entry storage has no reset; validity is tracked by count and the pointers
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= dec;
    end

    // occupancy, pointers and accepted-instruction counter; flush drops entries but keeps the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            wptr         <= '0;
            rptr         <= '0;
            decode_count <= '0;
        end else if (flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push)
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (pop)
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            count        <= count + CW'(push) - CW'(pop);
            decode_count <= decode_count + 32'(push);
        end
    end

    assign head        = out_valid ? mem[rptr] : '0;
    assign rd          = head.rd;
    assign imm         = head.imm;
    assign alu_control = head.alu;
    assign result      = head.result;
    assign target      = head.target;
    assign jump        = head.jump;
    assign wb_en       = head.wb_en;
    assign misaligned  = head.misaligned;
    assign illegal     = head.illegal;
endmodule

// File: tb/tb_decode_upperimm_stage.sv
// tb_decode_upperimm_stage: directed checks of decode, FIFO backpressure, flush and reset
module tb_decode_upperimm_stage;
    localparam logic [4:0] ALU_LUI   = 5'd20;
    localparam logic [4:0] ALU_AUIPC = 5'd21;
    localparam logic [4:0] ALU_JAL   = 5'd22;

    logic clk = 0, rst = 1, flush = 0;
    int checks = 0, errors = 0;
    logic [31:0] exp_dc = 0;

    logic        d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 0;
    logic [31:0] d_instr = 0, d_pc = 0, d_imm, d_result, d_target, d_decode_count;
    logic [4:0]  d_rd, d_alu;
    logic        d_jump, d_wb_en, d_mis, d_ill;

    logic        w_in_valid = 0, w_in_ready, w_out_valid, w_out_ready = 0;
    logic [31:0] w_instr = 0, w_decode_count;
    logic [63:0] w_pc = 0, w_imm, w_result, w_target;
    logic [4:0]  w_rd, w_alu;
    logic        w_jump, w_wb_en, w_mis, w_ill;

    always #5 clk = ~clk;

    decode_upperimm_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .instruction_code(d_instr), .pc(d_pc), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .rd(d_rd), .imm(d_imm), .alu_control(d_alu), .result(d_result), .target(d_target),
        .jump(d_jump), .wb_en(d_wb_en), .misaligned(d_mis), .illegal(d_ill), .decode_count(d_decode_count));

    decode_upperimm_stage #(.XLEN(64), .DEPTH(1)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .instruction_code(w_instr), .pc(w_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .rd(w_rd), .imm(w_imm), .alu_control(w_alu), .result(w_result), .target(w_target),
        .jump(w_jump), .wb_en(w_wb_en), .misaligned(w_mis), .illegal(w_ill), .decode_count(w_decode_count));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pcv);
        d_instr = instr;
        d_pc = pcv;
        d_in_valid = 1;
        step();
        d_in_valid = 0;
        exp_dc++;
    endtask

    task automatic drain();
        d_out_ready = 1;
        step();
        d_out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) step();
        rst = 0;
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", d_in_ready); end
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", d_out_valid); end
        checks++; if (d_decode_count !== 32'd0) begin errors++; $display("FAIL reset_decode_count got %0h exp 0", d_decode_count); end
        checks++; if (d_result !== 32'd0 || d_alu !== 5'd0 || d_rd !== 5'd0) begin errors++; $display("FAIL reset_data got result=%0h alu=%0h rd=%0h exp 0", d_result, d_alu, d_rd); end
        checks++; if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin errors++; $display("FAIL reset_w got in_ready=%0b out_valid=%0b exp 1/0", w_in_ready, w_out_valid); end
    endtask

    task automatic test_lui();
        send(32'h123452B7, 32'h40);
        checks++; if (d_out_valid !== 1'b1) begin errors++; $display("FAIL lui_valid got %0b exp 1", d_out_valid); end
        checks++; if (d_rd !== 5'd5) begin errors++; $display("FAIL lui_rd got %0d exp 5", d_rd); end
        checks++; if (d_imm !== 32'h12345000 || d_result !== 32'h12345000) begin errors++; $display("FAIL lui_val got imm=%0h result=%0h exp 12345000", d_imm, d_result); end
        checks++; if (d_wb_en !== 1'b1 || d_jump !== 1'b0 || d_ill !== 1'b0) begin errors++; $display("FAIL lui_flags got wb=%0b jump=%0b ill=%0b exp 1/0/0", d_wb_en, d_jump, d_ill); end
        checks++; if (d_alu !== ALU_LUI) begin errors++; $display("FAIL lui_alu got %0d exp %0d", d_alu, ALU_LUI); end
        checks++; if (d_decode_count !== exp_dc) begin errors++; $display("FAIL lui_count got %0d exp %0d", d_decode_count, exp_dc); end
        drain();
        checks++; if (d_out_valid !== 1'b0 || d_result !== 32'd0) begin errors++; $display("FAIL lui_pop got valid=%0b result=%0h exp 0/0", d_out_valid, d_result); end
    endtask

    task automatic test_auipc();
        send(32'h00001517, 32'h1000);
        checks++; if (d_rd !== 5'd10) begin errors++; $display("FAIL auipc_rd got %0d exp 10", d_rd); end
        checks++; if (d_result !== 32'h2000 || d_imm !== 32'h1000) begin errors++; $display("FAIL auipc_val got result=%0h imm=%0h exp 2000/1000", d_result, d_imm); end
        checks++; if (d_alu !== ALU_AUIPC || d_target !== 32'd0 || d_jump !== 1'b0) begin errors++; $display("FAIL auipc_misc got alu=%0d target=%0h jump=%0b", d_alu, d_target, d_jump); end
        drain();
    endtask

    task automatic test_jal();
        send(32'h008000EF, 32'h100);
        checks++; if (d_rd !== 5'd1 || d_result !== 32'h104) begin errors++; $display("FAIL jal_rd_result got rd=%0d result=%0h exp 1/104", d_rd, d_result); end
        checks++; if (d_target !== 32'h108 || d_imm !== 32'h8) begin errors++; $display("FAIL jal_target got target=%0h imm=%0h exp 108/8", d_target, d_imm); end
        checks++; if (d_jump !== 1'b1 || d_mis !== 1'b0 || d_wb_en !== 1'b1 || d_alu !== ALU_JAL) begin errors++; $display("FAIL jal_flags got jump=%0b mis=%0b wb=%0b alu=%0d", d_jump, d_mis, d_wb_en, d_alu); end
        drain();
        send(32'h002000EF, 32'h100);
        checks++; if (d_target !== 32'h102 || d_mis !== 1'b1) begin errors++; $display("FAIL jal_misaligned got target=%0h mis=%0b exp 102/1", d_target, d_mis); end
        drain();
        send(32'hFFDFF0EF, 32'h100);
        checks++; if (d_imm !== 32'hFFFFFFFC || d_target !== 32'hFC || d_mis !== 1'b0) begin errors++; $display("FAIL jal_negative got imm=%0h target=%0h mis=%0b exp FFFFFFFC/FC/0", d_imm, d_target, d_mis); end
        drain();
    endtask

    task automatic test_illegal();
        send(32'h00000013, 32'h40);
        checks++; if (d_out_valid !== 1'b1 || d_ill !== 1'b1) begin errors++; $display("FAIL ill_flag got valid=%0b ill=%0b exp 1/1", d_out_valid, d_ill); end
        checks++; if (d_wb_en !== 1'b0 || d_alu !== 5'd0 || d_rd !== 5'd0 || d_imm !== 32'd0 || d_result !== 32'd0) begin errors++; $display("FAIL ill_zero got wb=%0b alu=%0d rd=%0d imm=%0h result=%0h exp all 0", d_wb_en, d_alu, d_rd, d_imm, d_result); end
        drain();
        send(32'h12345037, 32'h40);
        checks++; if (d_wb_en !== 1'b0 || d_result !== 32'h12345000 || d_ill !== 1'b0) begin errors++; $display("FAIL rd0_wb got wb=%0b result=%0h ill=%0b exp 0/12345000/0", d_wb_en, d_result, d_ill); end
        drain();
    endtask

    task automatic test_backpressure();
        d_out_ready = 0;
        send(32'h000010B7, 32'h0);
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %0b exp 1", d_in_ready); end
        send(32'h00002137, 32'h0);
        checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %0b exp 0", d_in_ready); end
        d_instr = 32'h000031B7;
        d_in_valid = 1;
        step();
        checks++; if (d_in_ready !== 1'b0 || d_rd !== 5'd1 || d_decode_count !== exp_dc) begin errors++; $display("FAIL bp_hold got ready=%0b rd=%0d count=%0d exp 0/1/%0d", d_in_ready, d_rd, d_decode_count, exp_dc); end
        d_out_ready = 1;
        step();
        checks++; if (d_rd !== 5'd2 || d_in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop1 got rd=%0d ready=%0b exp 2/1", d_rd, d_in_ready); end
        step();
        d_in_valid = 0;
        exp_dc++;
        checks++; if (d_rd !== 5'd3 || d_out_valid !== 1'b1 || d_decode_count !== exp_dc) begin errors++; $display("FAIL bp_pop2 got rd=%0d valid=%0b count=%0d exp 3/1/%0d", d_rd, d_out_valid, d_decode_count, exp_dc); end
        step();
        d_out_ready = 0;
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", d_out_valid); end
    endtask

    task automatic test_back_to_back();
        d_out_ready = 1;
        d_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            d_instr = {20'h0, 5'(i + 1), 7'h37};
            step();
            exp_dc++;
            checks++; if (d_out_valid !== 1'b1 || d_rd !== 5'(i + 1) || d_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_%0d got valid=%0b rd=%0d ready=%0b exp 1/%0d/1", i, d_out_valid, d_rd, d_in_ready, i + 1); end
        end
        d_in_valid = 0;
        step();
        d_out_ready = 0;
        checks++; if (d_out_valid !== 1'b0 || d_decode_count !== exp_dc) begin errors++; $display("FAIL b2b_end got valid=%0b count=%0d exp 0/%0d", d_out_valid, d_decode_count, exp_dc); end
    endtask

    task automatic test_flush();
        send(32'h000010B7, 32'h0);
        send(32'h00002137, 32'h0);
        flush = 1;
        d_in_valid = 1;
        d_out_ready = 1;
        d_instr = 32'h000031B7;
        step();
        flush = 0;
        d_in_valid = 0;
        d_out_ready = 0;
        checks++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1 || d_rd !== 5'd0) begin errors++; $display("FAIL flush_empty got valid=%0b ready=%0b rd=%0d exp 0/1/0", d_out_valid, d_in_ready, d_rd); end
        checks++; if (d_decode_count !== exp_dc) begin errors++; $display("FAIL flush_count got %0d exp %0d", d_decode_count, exp_dc); end
        step();
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL flush_stay got %0b exp 0", d_out_valid); end
    endtask

    task automatic test_xlen64();
        w_instr = 32'h800000B7;
        w_pc = 64'h0;
        w_in_valid = 1;
        step();
        w_in_valid = 0;
        checks++; if (w_out_valid !== 1'b1 || w_rd !== 5'd1) begin errors++; $display("FAIL x64_lui_valid got valid=%0b rd=%0d exp 1/1", w_out_valid, w_rd); end
        checks++; if (w_imm !== 64'hFFFFFFFF80000000 || w_result !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL x64_lui_sext got imm=%0h result=%0h exp FFFFFFFF80000000", w_imm, w_result); end
        checks++; if (w_in_ready !== 1'b0) begin errors++; $display("FAIL x64_depth1_full got %0b exp 0", w_in_ready); end
        w_out_ready = 1;
        w_instr = 32'h00001517;
        w_pc = 64'hFFFFFFFFFFFFF000;
        w_in_valid = 1;
        step();
        checks++; if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin errors++; $display("FAIL x64_gap got valid=%0b ready=%0b exp 0/1", w_out_valid, w_in_ready); end
        w_out_ready = 0;
        step();
        w_in_valid = 0;
        checks++; if (w_out_valid !== 1'b1 || w_result !== 64'd0 || w_imm !== 64'h1000 || w_rd !== 5'd10) begin errors++; $display("FAIL x64_auipc_wrap got valid=%0b result=%0h imm=%0h rd=%0d exp 1/0/1000/10", w_out_valid, w_result, w_imm, w_rd); end
        w_out_ready = 1;
        step();
        w_out_ready = 0;
        checks++; if (w_out_valid !== 1'b0 || w_decode_count !== 32'd2) begin errors++; $display("FAIL x64_end got valid=%0b count=%0d exp 0/2", w_out_valid, w_decode_count); end
    endtask

    task automatic test_reset_mid();
        send(32'h000010B7, 32'h0);
        send(32'h00002137, 32'h0);
        rst = 1;
        flush = 1;
        step();
        checks++; if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got ready=%0b valid=%0b exp 1/0", d_in_ready, d_out_valid); end
        checks++; if (d_decode_count !== 32'd0 || w_decode_count !== 32'd0) begin errors++; $display("FAIL rstmid_count got %0d/%0d exp 0/0", d_decode_count, w_decode_count); end
        checks++; if (d_rd !== 5'd0 || d_result !== 32'd0 || d_imm !== 32'd0 || d_wb_en !== 1'b0) begin errors++; $display("FAIL rstmid_data got rd=%0d result=%0h imm=%0h wb=%0b exp 0", d_rd, d_result, d_imm, d_wb_en); end
        rst = 0;
        flush = 0;
        exp_dc = 0;
        send(32'h123452B7, 32'h0);
        checks++; if (d_decode_count !== exp_dc || d_rd !== 5'd5) begin errors++; $display("FAIL rstmid_resume got count=%0d rd=%0d exp %0d/5", d_decode_count, d_rd, exp_dc); end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lui();
        test_auipc();
        test_jal();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_xlen64();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_upperimm_stage.md
# decode_upperimm_stage

Pipelined decode stage for the RV32/RV64 upper-immediate and direct-jump instructions: LUI, AUIPC and JAL. It accepts instruction/PC pairs over a valid/ready handshake and decodes them in one cycle. It computes the write-back value and jump target, then holds results in a small output FIFO so the downstream execute/write-back stage can apply backpressure without stalling fetch every cycle. It sits between the fetch buffer and the ALU/branch unit, and drives `alu_control` codes from `processor_defines.sv`.

## Interface
- `XLEN`, 32: datapath width, 32 or 64. Immediates and results are sign-extended to XLEN.
- `DEPTH`, 2: output FIFO entries, ≥1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  instruction/PC pair offered.
- `in_ready`  out  1  stage can accept.
- `instruction_code`  in  32  raw instruction.
- `pc`  in  XLEN  address of `instruction_code`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes head entry.
- `rd`  out  5  destination register.
- `imm`  out  XLEN  decoded immediate, sign-extended.
- `alu_control`  out  5  `LUI`, `AUIPC` or `JAL` code; 0 if illegal.
- `result`  out  XLEN  write-back value.
- `target`  out  XLEN  jump target (JAL), else 0.
- `jump`  out  1  entry is JAL.
- `wb_en`  out  1  register write required.
- `misaligned`  out  1  JAL target not 4-byte aligned.
- `illegal`  out  1  opcode not LUI/AUIPC/JAL.
- `decode_count`  out  32  entries accepted since reset, wrapping.

## Operation
- Accept (push) occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Decode is combinational on the accepted input, and the decoded entry is written into the FIFO tail.
- Opcodes:
  - `0110111` LUI: `imm = sext({instr[31:12],12'b0})`, `result = imm`.
  - `0010111` AUIPC: same `imm`, `result = pc + imm` mod 2^XLEN.
  - `1101111` JAL: `imm = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})`, `result = pc + 4`, `target = pc + imm`, `jump = 1`.
- Any other opcode:
  - Still enqueued with `illegal = 1`.
  - `rd`, `imm`, `result`, `target`, `alu_control`, `jump`, `wb_en`, `misaligned` all 0.
- `rd = instr[11:7]` for legal opcodes.
- `wb_en = legal && rd != 0`.
- `misaligned = jump && target[1:0] != 0`.
- FIFO holds `count` entries, 0..DEPTH.
- `in_ready = (count < DEPTH)`, derived from registered `count` only. It has no combinational path from `out_ready` or `in_valid`.
- `out_valid = (count != 0)`. When `out_valid` is 0, every output data field reads 0.
- Simultaneous push and pop is legal whenever `count < DEPTH`: `count` is unchanged, and order is preserved.
- `decode_count` increments on every push, wraps from 0xFFFFFFFF to 0, and is not cleared by `flush`.
- `flush` empties the FIFO next cycle (`count = 0`). Any push or pop in the same cycle is discarded and not counted.
- `rst` sets `count = 0` and `decode_count = 0`. It takes priority over `flush`.

## Timing
- Latency: push in cycle N → `out_valid` and data visible in cycle N+1 when the FIFO was empty; otherwise once the entry reaches the head.
- Throughput:
  - DEPTH≥2 sustains one instruction per cycle with `out_ready` held high.
  - DEPTH=1 sustains one per two cycles, because `in_ready` is low while full.
- Head outputs are stable while `out_valid && !out_ready`.
- Reset values: `in_ready = 1`, `out_valid = 0`, all data outputs 0, `decode_count = 0`.
- Reset mid-operation drops all entries. `in_ready` returns to 1 in the cycle after reset is sampled.

## Test plan
- LUI: `instruction_code = 0x123452B7`, `pc = 0x40` → next cycle `out_valid = 1`, `rd = 5`, `imm = result = 0x12345000`, `wb_en = 1`, `jump = 0`.
- AUIPC/JAL:
  - `0x00001517` at `pc = 0x1000` → `rd = 10`, `result = 0x2000`.
  - `0x008000EF` at `pc = 0x100` → `rd = 1`, `result = 0x104`, `target = 0x108`, `jump = 1`, `misaligned = 0`.
- Backpressure: DEPTH=2, `out_ready = 0`, push three instructions back-to-back → `in_ready` drops after the second. Release `out_ready` → the entries pop in order, and the third is then accepted.
- Flush/illegal:
  - Push `0x00000013` (ADDI) → `illegal = 1`, `wb_en = 0`, `alu_control = 0`.
  - With two entries queued, assert `flush` → `out_valid = 0` next cycle, and `decode_count` retains its value.
- XLEN=64: LUI `0x800000B7` → `imm = result = 0xFFFFFFFF80000000`. AUIPC at `pc = 0xFFFFFFFFFFFFF000` with imm 0x1000 → result wraps to 0.
- Rst with `rst = 1` during a full FIFO plus `flush` → next cycle `count = 0`, `in_ready = 1`, `decode_count = 0`, all outputs 0.
